// File: rtl/branch_resolver.sv
// branch_resolver: 2-bit saturating BHT predictor with a one-entry resolve stage and mispredict redirect.
// Define BRANCH_RESOLVER_GHIST_EN to XOR a global outcome history into the BHT index.
module branch_resolver #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lookup_pc_i,
    output logic        lookup_taken_o,
    input  logic        resolve_valid_i,
    input  logic [31:0] resolve_pc_i,
    input  logic        resolve_taken_i,
    input  logic        resolve_pred_i,
    input  logic [31:0] resolve_target_i,
    input  logic        stall_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            bht [ENTRIES];
    logic                  st_valid, st_taken, st_pred, capture;
    logic [31:0]           st_pc, st_target;
    logic [INDEX_BITS-1:0] lookup_idx, st_idx;
    logic [1:0]            st_cur, st_next;
    logic                  unused_lookup_bits;

    assign unused_lookup_bits = ^{lookup_pc_i[31:INDEX_BITS+2], lookup_pc_i[1:0]};
    assign capture = resolve_valid_i & ~stall_i & ~mispredict_o;

`ifdef BRANCH_RESOLVER_GHIST_EN
    logic [INDEX_BITS-1:0] hist, st_hist;

    // the stage keeps the history seen at capture so the update hits the entry fetch used
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist    <= '0;
            st_hist <= '0;
        end else begin
            if (st_valid) hist <= {hist[INDEX_BITS-2:0], st_taken};
            if (capture) st_hist <= hist;
        end
    end

    assign lookup_idx = lookup_pc_i[INDEX_BITS+1:2] ^ hist;
    assign st_idx     = st_pc[INDEX_BITS+1:2] ^ st_hist;
`else
    assign lookup_idx = lookup_pc_i[INDEX_BITS+1:2];
    assign st_idx     = st_pc[INDEX_BITS+1:2];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_valid  <= 1'b0;
            st_pc     <= '0;
            st_target <= '0;
            st_taken  <= 1'b0;
            st_pred   <= 1'b0;
        end else begin
            st_valid <= capture;
            if (capture) begin
                st_pc     <= resolve_pc_i;
                st_target <= resolve_target_i;
                st_taken  <= resolve_taken_i;
                st_pred   <= resolve_pred_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= INIT_STATE;
        end else if (st_valid) begin
            bht[st_idx] <= st_next;
        end
    end

    assign st_cur  = bht[st_idx];
    assign st_next = st_taken ? (st_cur == 2'b11 ? 2'b11 : st_cur + 2'd1)
                              : (st_cur == 2'b00 ? 2'b00 : st_cur - 2'd1);

    // a lookup racing the pending write sees the value about to land
    assign lookup_taken_o = (st_valid && lookup_idx == st_idx) ? st_next[1] : bht[lookup_idx][1];
    assign mispredict_o   = st_valid & (st_taken ^ st_pred);
    assign redirect_pc_o  = mispredict_o ? (st_taken ? st_target : st_pc + 32'd4) : 32'h0;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vector table, reset corner sequences and a randomized run against a counter-array model.
module tb_branch_resolver;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic [31:0] lookup_pc_i = '0, resolve_pc_i = '0, resolve_target_i = '0;
    logic        resolve_valid_i = 1'b0, resolve_taken_i = 1'b0, resolve_pred_i = 1'b0, stall_i = 1'b0;
    logic        lookup_taken_o, mispredict_o;
    logic [31:0] redirect_pc_o;

    int n_checks = 0, n_fail = 0;

    int          m_ctr [64];
    bit          m_pv, m_pt, m_pp;
    int          m_pidx;
    logic [31:0] m_ppc, m_ptg;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        taken, pred;
        logic [31:0] target;
        logic        stall;
        logic [31:0] lpc;
        logic        mis;
        logic [31:0] red;
        logic        lk;
    } vec_t;
    vec_t tbl[$];

    branch_resolver dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_pc_i(lookup_pc_i), .lookup_taken_o(lookup_taken_o),
        .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
        .resolve_taken_i(resolve_taken_i), .resolve_pred_i(resolve_pred_i),
        .resolve_target_i(resolve_target_i), .stall_i(stall_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic tk, input logic pd,
                         input logic [31:0] tg, input logic st, input logic [31:0] lpc);
        resolve_valid_i = rv; resolve_pc_i = pc; resolve_taken_i = tk;
        resolve_pred_i = pd; resolve_target_i = tg; stall_i = st; lookup_pc_i = lpc;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_pv = 0;
    endtask

    function automatic void add(logic rv, logic [31:0] pc, logic tk, logic pd, logic [31:0] tg,
                                logic st, logic [31:0] lpc, logic mis, logic [31:0] red, logic lk);
        vec_t v;
        v.rv = rv; v.pc = pc; v.taken = tk; v.pred = pd; v.target = tg; v.stall = st;
        v.lpc = lpc; v.mis = mis; v.red = red; v.lk = lk;
        tbl.push_back(v);
    endfunction

    function automatic int sat(int c, bit up);
        return up ? (c + 1 > 3 ? 3 : c + 1) : (c - 1 < 0 ? 0 : c - 1);
    endfunction

    initial begin
        logic        rv, st, tk, pd, exp_mis, exp_lk;
        logic [31:0] pc, tg, lpc, exp_red;
        int          li, c;

        // during reset: outputs idle, every entry predicts not-taken
        #1;
        check("rst_mis", mispredict_o, 0);
        check("rst_red", redirect_pc_o, 0);
        for (int i = 0; i < 64; i++) begin
            lookup_pc_i = 32'h0040_0000 | (i << 2);
            #1 check($sformatf("rst_lk%0d", i), lookup_taken_o, 0);
        end
        do_reset();

        add(0, 0, 0, 0, 0, 0, 32'h0040_0010, 0, 0, 0);
        add(1, 32'h0040_0010, 1, 1, 0, 0, 32'h0040_0010, 0, 0, 0);
        add(1, 32'h0040_0010, 1, 1, 0, 0, 32'h0040_0010, 0, 0, 1);
        add(1, 32'h0040_0010, 1, 1, 0, 0, 32'h0040_0010, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 32'h0040_0010, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 32'h0040_0010, 0, 0, 1);
        add(1, 32'h0040_0010, 0, 0, 0, 0, 32'h0040_0010, 0, 0, 1);
        add(1, 32'h0040_0010, 0, 0, 0, 0, 32'h0040_0010, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 32'h0040_0010, 0, 0, 0);
        add(1, 32'h0040_0020, 1, 0, 32'h0040_0100, 0, 32'h0040_0020, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'h0040_0020, 1, 32'h0040_0100, 1);
        add(0, 0, 0, 0, 0, 0, 32'h0040_0020, 0, 0, 1);
        add(1, 32'hFFFF_FFFC, 0, 1, 32'h1234_5678, 0, 32'hFFFF_FFFC, 0, 0, 0);
        add(1, 32'hFFFF_FFFC, 1, 1, 32'h0BAD_0000, 0, 32'hFFFF_FFFC, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        add(1, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        add(1, 32'h0040_0030, 1, 0, 32'h0040_0100, 1, 32'h0040_0030, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'h0040_0030, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk_i);
            drive(tbl[i].rv, tbl[i].pc, tbl[i].taken, tbl[i].pred, tbl[i].target, tbl[i].stall, tbl[i].lpc);
            #1;
            check($sformatf("vec%0d_mis", i), mispredict_o, tbl[i].mis);
            check($sformatf("vec%0d_red", i), redirect_pc_o, tbl[i].red);
            check($sformatf("vec%0d_lk", i), lookup_taken_o, tbl[i].lk);
        end

        // reset asserted while a mispredicting entry sits in the stage
        do_reset();
        @(negedge clk_i);
        drive(1, 32'h0040_0040, 1, 0, 32'h0040_0200, 0, 32'h0040_0040);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 32'h0040_0040);
        #1 check("midrst_pre_mis", mispredict_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_mis", mispredict_o, 0);
        check("midrst_red", redirect_pc_o, 0);
        check("midrst_lk", lookup_taken_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 check("midrst_after_lk", lookup_taken_o, 0);
        @(posedge clk_i);
        #1 check("midrst_after_mis", mispredict_o, 0);

        // randomized run against the counter-array model, indices crowded onto 4 entries
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            rv  = ($urandom % 4) != 0;
            st  = ($urandom % 4) == 0;
            tk  = $urandom % 2;
            pd  = $urandom % 2;
            pc  = $urandom & ~32'h0000_00F0;
            tg  = $urandom;
            lpc = $urandom & ~32'h0000_00F0;
            drive(rv, pc, tk, pd, tg, st, lpc);
            #1;
            li = int'(lpc[7:2]);
            c  = m_ctr[li];
            if (m_pv && m_pidx == li) c = sat(c, m_pt);
            exp_lk  = c >= 2;
            exp_mis = m_pv && (m_pt != m_pp);
            exp_red = exp_mis ? (m_pt ? m_ptg : m_ppc + 32'd4) : 32'h0;
            check("rnd_mis", mispredict_o, exp_mis);
            check("rnd_red", redirect_pc_o, exp_red);
            check("rnd_lk", lookup_taken_o, exp_lk);
            @(posedge clk_i);
            if (m_pv) m_ctr[m_pidx] = sat(m_ctr[m_pidx], m_pt);
            m_pv = rv && !st && !exp_mis;
            if (m_pv) begin
                m_pidx = int'(pc[7:2]); m_pt = tk; m_pp = pd; m_ppc = pc; m_ptg = tg;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning log2 of branch history table (BHT) entry count.
REQ-002 SHALL have parameter INIT_STATE, default 2'b01, meaning reset value of every 2-bit counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port lookup_pc_i  input  32  fetch-stage PC to predict.
REQ-006 SHALL have port lookup_taken_o  output  1  predicted direction for lookup_pc_i, combinational.
REQ-007 SHALL have port resolve_valid_i  input  1  execute stage presents a resolved conditional branch (BEQ/BNE).
REQ-008 SHALL have port resolve_pc_i  input  32  PC of the resolved branch.
REQ-009 SHALL have port resolve_taken_i  input  1  actual outcome.
REQ-010 SHALL have port resolve_pred_i  input  1  direction that fetch predicted for this branch.
REQ-011 SHALL have port resolve_target_i  input  32  computed branch target.
REQ-012 SHALL have port stall_i  input  1  execute stalled; blocks capture of a new resolve.
REQ-013 SHALL have port mispredict_o  output  1  one-cycle flush pulse.
REQ-014 SHALL have port redirect_pc_o  output  32  corrected fetch PC, valid while mispredict_o=1.

Function
REQ-015 SHALL hold 2^INDEX_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter MSB.
REQ-016 SHALL index the BHT with pc[INDEX_BITS+1:2] (hashed per REQ-030 when enabled).
REQ-017 SHALL capture resolve into a one-entry stage register at edge N when resolve_valid_i=1, stall_i=0, and mispredict_o=0.
REQ-018 SHALL, in cycle N+1 with stage valid, read the indexed counter, increment (taken) or decrement (not taken) with saturation at 11/00, and write it at the N+1 edge.
REQ-019 SHALL forward the pending new counter value to lookup_taken_o in cycle N+1 when the lookup index equals the stage index.
REQ-020 SHALL assert mispredict_o combinationally from the stage register in cycle N+1 for exactly one cycle iff stage valid and taken != pred.
REQ-021 SHALL drive redirect_pc_o = target when taken, else stage pc + 4 (32-bit wrap), while mispredict_o=1; 32'h0 otherwise.
REQ-022 SHALL drop (never capture) a resolve presented in a cycle where mispredict_o=1 (wrong-path instruction).
REQ-023 SHALL commit an already-captured stage entry regardless of stall_i.
REQ-024 SHALL handle back-to-back updates to one index without loss: the second update reads the value written by the first.
REQ-025 SHALL clear stage valid at N+1 edge unless a new resolve is captured at that edge.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously set every counter to INIT_STATE, stage valid to 0, history to 0.
REQ-027 SHALL drive mispredict_o=0, redirect_pc_o=32'h0, lookup_taken_o=INIT_STATE[1] during reset.
REQ-028 SHALL discard any captured update when reset asserts mid-operation; no counter write occurs.

Configuration
REQ-029 SHALL compile global history in only when macro BRANCH_RESOLVER_GHIST_EN is defined.
REQ-030 SHALL, with BRANCH_RESOLVER_GHIST_EN, keep an INDEX_BITS-bit history register, index = pc bits XOR history for both lookup and update (update uses history captured with the resolve), and shift in the outcome {hist[INDEX_BITS-2:0], taken} at each commit.
REQ-031 SHALL, without BRANCH_RESOLVER_GHIST_EN, have no history register and index by pc bits alone.

Verification
REQ-032 SHALL verify: after reset, lookup_pc_i=32'h0040_0010 -> lookup_taken_o=0; all entries read 01.
REQ-033 SHALL verify: three taken resolves at pc 32'h0040_0010 on consecutive cycles -> counter 01->10->11->11, lookup_taken_o=1 from the first commit cycle (forwarded).
REQ-034 SHALL verify: resolve pc=32'h0040_0020, taken=1, pred=0, target=32'h0040_0100 -> next cycle mispredict_o=1, redirect_pc_o=32'h0040_0100, one cycle only.
REQ-035 SHALL verify: taken=0, pred=1, pc=32'hFFFF_FFFC -> redirect_pc_o=32'h0000_0000 (wrap); a resolve presented in that cycle is ignored (counter unchanged).
REQ-036 SHALL verify: stall_i=1 with resolve_valid_i=1 -> no capture, no mispredict; rst_ni pulsed low while stage valid -> counter remains INIT_STATE.
